rtc_bus_scheduler: RTL and testbench

Sequences the external RTC's multiplexed address/data bus (CS, AD, RD, WR, active low) and shares it between two requesters. The first requester is the microcontroller port logic, which issues single reads and writes. The second is an internal refresh scheduler that periodically sweeps the time registers into a consistent shadow copy for the VGA and display path. The block sits between the micro's port decoding and the RTC pins; the top level owns only the tristate driver (`datRTC = bus_oe ? bus_dout : 'z`).

---
 rtl/rtc_bus_pkg.sv | 24 ++
 rtl/rtc_bus_phy.sv | 127 ++++++++++++
 rtl/rtc_bus_scheduler.sv | 165 ++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and default register map for the RTC bus scheduler.
package rtc_bus_pkg;

    // Bus phase sequence of one RTC transaction
    typedef enum logic [2:0] {
        IDLE,
        A_STB,
        A_HLD,
        D_STB,
        D_HLD,
        RECOV
    } phase_t;

    // Which requester owns the current transaction
    typedef enum logic {
        OWN_MICRO,
        OWN_REFRESH
    } owner_t;

    // Default location and size of the time-register block that is mirrored
    localparam logic [7:0] RTC_ADDR_SHADOW_BASE = 8'h21;
    localparam int         RTC_SHADOW_LEN       = 6;

endpackage

// File: rtl/rtc_bus_phy.sv
// Phase sequencer for the RTC multiplexed bus: runs one read or write
// through address strobe/hold, data strobe/hold and recovery phases.
module rtc_bus_phy
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       idle,
    output logic       done,
    output logic [7:0] rdata,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    localparam int            TW     = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(T_PHASE - 1);

    phase_t      r_state;
    logic [TW-1:0] r_timer;
    logic        r_is_write;
    logic [7:0]  r_data;
    logic [7:0]  r_rdata;
    logic        r_cs;
    logic        r_ad;
    logic        r_rd;
    logic        r_wr;
    logic        r_oe;
    logic [7:0]  r_dout;

    logic        w_last;

    assign w_last   = (r_timer == T_LAST);
    assign idle     = (r_state == IDLE);
    assign done     = (r_state == RECOV) && w_last;
    assign rdata    = r_rdata;
    assign CS       = r_cs;
    assign AD       = r_ad;
    assign RD       = r_rd;
    assign WR       = r_wr;
    assign bus_oe   = r_oe;
    assign bus_dout = r_dout;

    // Phase FSM: strobes are computed for the next phase so every pin is a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= 8'h00;
            r_cs       <= 1'b1;
            r_ad       <= 1'b1;
            r_rd       <= 1'b1;
            r_wr       <= 1'b1;
            r_oe       <= 1'b0;
            r_dout     <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= A_STB;
                        r_timer    <= '0;
                        r_is_write <= write;
                        r_data     <= data;
                        r_cs       <= 1'b0;
                        r_ad       <= 1'b0;
                        r_wr       <= 1'b0;
                        r_oe       <= 1'b1;
                        r_dout     <= addr;
                    end
                end
                default: begin
                    if (w_last) begin
                        r_timer <= '0;
                        case (r_state)
                            A_STB: begin
                                r_state <= A_HLD;
                                r_wr    <= 1'b1;
                            end
                            A_HLD: begin
                                r_state <= D_STB;
                                r_ad    <= 1'b1;
                                if (r_is_write) begin
                                    r_wr   <= 1'b0;
                                    r_dout <= r_data;
                                end else begin
                                    r_rd <= 1'b0;
                                    r_oe <= 1'b0;
                                end
                            end
                            D_STB: begin
                                // Read data is taken on the final data-strobe cycle
                                r_state <= D_HLD;
                                r_wr    <= 1'b1;
                                r_rd    <= 1'b1;
                                if (!r_is_write) begin
                                    r_rdata <= bus_din;
                                end
                            end
                            D_HLD: begin
                                r_state <= RECOV;
                                r_cs    <= 1'b1;
                                r_oe    <= 1'b0;
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Shares the RTC bus between micro port requests and a periodic sweep that
// snapshots the time registers into a coherent shadow copy.
module rtc_bus_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int         T_PHASE        = 4,
    parameter int         REFRESH_CYCLES = 1_000_000,
    parameter logic [7:0] SHADOW_BASE    = RTC_ADDR_SHADOW_BASE,
    parameter int         SHADOW_LEN     = RTC_SHADOW_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic [2:0] shadow_sel,
    output logic [7:0] shadow_data,
    output logic       shadow_epoch,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    localparam int            CW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [2:0]    I_LAST = 3'(SHADOW_LEN - 1);

    logic [CW-1:0] r_cnt;
    owner_t        r_owner;
    logic          r_cur_write;
    logic [7:0]    r_cur_addr;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_rdata;
    logic          r_sweep_pending;
    logic [2:0]    r_idx;
    logic [7:0]    r_staging [8];
    logic [7:0]    r_shadow  [8];
    logic          r_epoch;

    logic          w_idle;
    logic          w_done;
    logic [7:0]    w_rdata;
    logic          w_tick;
    logic          w_ref_win;
    logic          w_start;
    logic [7:0]    w_ref_addr;
    logic [7:0]    w_off;
    logic          w_in_range;

    assign w_tick     = (r_cnt == C_LAST);
    assign w_ref_win  = w_idle && r_sweep_pending && (!req_valid || (r_owner == OWN_MICRO));
    assign req_ready  = !reset && w_idle && req_valid && !w_ref_win;
    assign w_start    = !reset && w_idle && (w_ref_win || req_valid);
    assign w_ref_addr = SHADOW_BASE + {5'd0, r_idx};
    assign w_off      = r_cur_addr - SHADOW_BASE;
    assign w_in_range = (w_off < 8'(SHADOW_LEN));

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign shadow_epoch = r_epoch;
    assign shadow_data  = ({1'b0, shadow_sel} < 4'(SHADOW_LEN)) ? r_shadow[shadow_sel] : 8'h00;

    rtc_bus_phy #(
        .T_PHASE (T_PHASE)
    ) u_phy (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .write    (w_ref_win ? 1'b0 : req_write),
        .addr     (w_ref_win ? w_ref_addr : req_addr),
        .data     (req_wdata),
        .idle     (w_idle),
        .done     (w_done),
        .rdata    (w_rdata),
        .CS       (CS),
        .AD       (AD),
        .RD       (RD),
        .WR       (WR),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din)
    );

    // Free-running refresh period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Remember who owns the transaction in flight; it also serves as last grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= OWN_REFRESH;
            r_cur_write <= 1'b0;
            r_cur_addr  <= 8'h00;
        end else if (w_start) begin
            r_owner     <= w_ref_win ? OWN_REFRESH : OWN_MICRO;
            r_cur_write <= !w_ref_win && req_write;
            r_cur_addr  <= req_addr;
        end
    end

    // Completion pulse and read data for micro transactions only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_rsp_valid <= w_done && (r_owner == OWN_MICRO);
            if (w_done && (r_owner == OWN_MICRO) && !r_cur_write) begin
                r_rsp_rdata <= w_rdata;
            end
        end
    end

    // Sweep sequencing, staging capture and atomic shadow commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sweep_pending <= 1'b0;
            r_idx           <= 3'd0;
            r_epoch         <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_staging[i] <= 8'h00;
                r_shadow[i]  <= 8'h00;
            end
        end else begin
            r_epoch <= 1'b0;
            if (w_done && (r_owner == OWN_REFRESH)) begin
                r_staging[r_idx] <= w_rdata;
                if (r_idx == I_LAST) begin
                    // Final read lands directly in shadow alongside the staged ones
                    for (int i = 0; i < 8; i++) begin
                        r_shadow[i] <= (3'(i) == r_idx) ? w_rdata : r_staging[i];
                    end
                    r_epoch         <= 1'b1;
                    r_sweep_pending <= 1'b0;
                    r_idx           <= 3'd0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else if (w_done && (r_owner == OWN_MICRO) && r_cur_write &&
                         r_sweep_pending && w_in_range) begin
                // A write into the mirrored block invalidates what was staged so far
                r_idx <= 3'd0;
            end else if (w_tick && !r_sweep_pending) begin
                r_sweep_pending <= 1'b1;
                r_idx           <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with a simple RTC register model.
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [2:0] shadow_sel = 3'd0;
    logic       req_ready, rsp_valid, shadow_epoch;
    logic [7:0] rsp_rdata, shadow_data, bus_dout, bus_din;
    logic       CS, AD, RD, WR, bus_oe;

    int n_tests = 0;
    int n_fail  = 0;

    rtc_bus_scheduler #(
        .T_PHASE        (2),
        .REFRESH_CYCLES (200),
        .SHADOW_BASE    (8'h21),
        .SHADOW_LEN     (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .shadow_sel   (shadow_sel),
        .shadow_data  (shadow_data),
        .shadow_epoch (shadow_epoch),
        .CS           (CS),
        .AD           (AD),
        .RD           (RD),
        .WR           (WR),
        .bus_dout     (bus_dout),
        .bus_oe       (bus_oe),
        .bus_din      (bus_din)
    );

    always #5 clk = ~clk;

    // RTC model and bus transaction log
    logic [7:0] mem [256];
    logic [7:0] m_addr = 8'h00;
    logic       prev_cs = 1'b1;
    logic [7:0] log_addr [256];
    logic       log_wr   [256];
    int         log_cyc  [256];
    int         log_n = 0;
    int         cyc = 0;
    int         rsp_cnt = 0;
    int         ep_cnt = 0;
    int         ep_cyc = 0;

    assign bus_din = mem[m_addr];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_cs <= CS;
        if (!CS && !AD && !WR && bus_oe && prev_cs && log_n < 256) begin
            log_addr[log_n] <= bus_dout;
            log_wr[log_n]   <= 1'b0;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
            m_addr          <= bus_dout;
        end
        if (!CS && AD && !WR && bus_oe && log_n > 0) begin
            mem[m_addr]       <= bus_dout;
            log_wr[log_n - 1] <= 1'b1;
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (shadow_epoch) begin
            ep_cnt <= ep_cnt + 1;
            ep_cyc <= cyc;
        end
    end

    // Per-cycle trace of one transaction, bit k = cycle k after acceptance
    logic [12:0] tr_cs, tr_ad, tr_wr, tr_rd, tr_oe, tr_rv;
    logic [7:0]  tr_dout  [13];
    logic [7:0]  tr_rdata [13];

    task automatic sample(input int k);
        tr_cs[k] = CS; tr_ad[k] = AD; tr_wr[k] = WR; tr_rd[k] = RD;
        tr_oe[k] = bus_oe; tr_rv[k] = rsp_valid;
        tr_dout[k] = bus_dout; tr_rdata[k] = rsp_rdata;
    endtask

    task automatic do_reset;
        @(posedge clk); #1 reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin acc = 1'b1; break; end
        end
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL txn_accept addr %h: got ready=0 expected ready=1", a);
            req_valid = 1'b0;
        end else begin
            sample(0);
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                if (k == 1) req_valid = 1'b0;
                @(negedge clk);
                sample(k);
            end
        end
    endtask

    task automatic test_reset;
        req_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
        @(posedge clk); #1 reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if ({CS, AD, RD, WR} !== 4'hF) begin n_fail++; $display("FAIL rst_strobes: got %h expected f", {CS, AD, RD, WR}); end
        n_tests++; if ({bus_oe, bus_dout} !== 9'h000) begin n_fail++; $display("FAIL rst_bus: got %h expected 000", {bus_oe, bus_dout}); end
        n_tests++; if ({rsp_valid, rsp_rdata, shadow_epoch} !== 10'h000) begin n_fail++; $display("FAIL rst_rsp: got %h expected 000", {rsp_valid, rsp_rdata, shadow_epoch}); end
        n_tests++; if (shadow_data !== 8'h00) begin n_fail++; $display("FAIL rst_shadow: got %h expected 00", shadow_data); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_novalid: got %b expected 0", req_ready); end
        req_valid = 1'b1; #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready_valid: got %b expected 1", req_ready); end
        req_valid = 1'b0;
    endtask

    task automatic test_write;
        do_reset;
        run_txn(1'b1, 8'h23, 8'h45);
        n_tests++; if (tr_cs !== 13'b1111000000001) begin n_fail++; $display("FAIL wr_cs: got %b expected 1111000000001", tr_cs); end
        n_tests++; if (tr_ad !== 13'b1111111100001) begin n_fail++; $display("FAIL wr_ad: got %b expected 1111111100001", tr_ad); end
        n_tests++; if (tr_wr !== 13'b1111110011001) begin n_fail++; $display("FAIL wr_wr: got %b expected 1111110011001", tr_wr); end
        n_tests++; if (tr_rd !== 13'b1111111111111) begin n_fail++; $display("FAIL wr_rd: got %b expected 1111111111111", tr_rd); end
        n_tests++; if (tr_oe !== 13'b0000111111110) begin n_fail++; $display("FAIL wr_oe: got %b expected 0000111111110", tr_oe); end
        n_tests++; if (tr_rv !== 13'b0100000000000) begin n_fail++; $display("FAIL wr_rsp: got %b expected 0100000000000", tr_rv); end
        n_tests++; if ({tr_dout[1], tr_dout[2]} !== 16'h2323) begin n_fail++; $display("FAIL wr_addr_out: got %h expected 2323", {tr_dout[1], tr_dout[2]}); end
        n_tests++; if ({tr_dout[5], tr_dout[6], tr_dout[8]} !== 24'h454545) begin n_fail++; $display("FAIL wr_data_out: got %h expected 454545", {tr_dout[5], tr_dout[6], tr_dout[8]}); end
        n_tests++; if (mem[8'h23] !== 8'h45) begin n_fail++; $display("FAIL wr_mem: got %h expected 45", mem[8'h23]); end
    endtask

    task automatic test_read;
        do_reset;
        run_txn(1'b1, 8'h22, 8'h59);
        run_txn(1'b0, 8'h22, 8'h00);
        n_tests++; if (tr_cs !== 13'b1111000000001) begin n_fail++; $display("FAIL rd_cs: got %b expected 1111000000001", tr_cs); end
        n_tests++; if (tr_wr !== 13'b1111111111001) begin n_fail++; $display("FAIL rd_wr: got %b expected 1111111111001", tr_wr); end
        n_tests++; if (tr_rd !== 13'b1111110011111) begin n_fail++; $display("FAIL rd_rd: got %b expected 1111110011111", tr_rd); end
        n_tests++; if (tr_oe !== 13'b0000000011110) begin n_fail++; $display("FAIL rd_oe: got %b expected 0000000011110", tr_oe); end
        n_tests++; if (tr_rv !== 13'b0100000000000) begin n_fail++; $display("FAIL rd_rsp: got %b expected 0100000000000", tr_rv); end
        n_tests++; if ({tr_rdata[11], tr_rdata[12]} !== 16'h5959) begin n_fail++; $display("FAIL rd_data: got %h expected 5959", {tr_rdata[11], tr_rdata[12]}); end
    endtask

    task automatic check_shadow(input string nm, input logic [7:0] e0, e1, e2, e3, e4, e5);
        logic [7:0] exp_s [8];
        exp_s = '{e0, e1, e2, e3, e4, e5, 8'h00, 8'h00};
        for (int s = 0; s < 8; s++) begin
            shadow_sel = 3'(s); #1;
            n_tests++;
            if (shadow_data !== exp_s[s]) begin n_fail++; $display("FAIL %s_shadow%0d: got %h expected %h", nm, s, shadow_data, exp_s[s]); end
        end
    endtask

    task automatic test_sweep;
        int base, ep0, r0;
        do_reset;
        for (int i = 0; i < 6; i++) run_txn(1'b1, 8'(8'h21 + i), 8'(i + 1));
        base = log_n; ep0 = ep_cnt; r0 = rsp_cnt;
        for (int i = 0; i < 400 && ep_cnt == ep0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_tests++; if (ep_cnt - ep0 !== 1) begin n_fail++; $display("FAIL sw_epochs: got %0d expected 1", ep_cnt - ep0); end
        n_tests++; if (log_n - base !== 6) begin n_fail++; $display("FAIL sw_txns: got %0d expected 6", log_n - base); end
        for (int j = 0; j < 6; j++) begin
            n_tests++;
            if ({log_wr[base + j], log_addr[base + j]} !== {1'b0, 8'(8'h21 + j)}) begin
                n_fail++; $display("FAIL sw_read%0d: got %h expected %h", j, {log_wr[base + j], log_addr[base + j]}, {1'b0, 8'(8'h21 + j)});
            end
        end
        n_tests++; if (ep_cyc - log_cyc[base] !== 65) begin n_fail++; $display("FAIL sw_latency: got %0d expected 65", ep_cyc - log_cyc[base]); end
        n_tests++; if (rsp_cnt !== r0) begin n_fail++; $display("FAIL sw_no_rsp: got %0d expected %0d", rsp_cnt, r0); end
        check_shadow("sw", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    endtask

    task automatic test_contention;
        int base, ep0, r0, acc_n, f;
        bit stop, got;
        logic [7:0] last_d;
        logic [10:0] wr_pat;
        do_reset;
        base = log_n; ep0 = ep_cnt; r0 = rsp_cnt; acc_n = 0; stop = 1'b0; last_d = 8'h00;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 8'h80;
        for (int i = 0; i < 1000 && !stop; i++) begin
            @(negedge clk);
            got = req_ready;
            if (got) begin
                acc_n++; last_d = req_wdata;
                if (ep_cnt != ep0) stop = 1'b1;
            end
            @(posedge clk); #1;
            if (got) req_wdata = req_wdata + 8'd1;
        end
        req_valid = 1'b0;
        n_tests++; if (!stop) begin n_fail++; $display("FAIL ct_timeout: got no epoch expected epoch"); end
        repeat (15) @(negedge clk);
        f = base;
        while (f < log_n && log_wr[f]) f++;
        for (int j = 0; j < 11; j++) wr_pat[j] = log_wr[f + j];
        n_tests++; if (wr_pat !== 11'b01010101010) begin n_fail++; $display("FAIL ct_alternate: got %b expected 01010101010", wr_pat); end
        for (int j = 0; j < 6; j++) begin
            n_tests++;
            if (log_addr[f + 2 * j] !== 8'(8'h21 + j)) begin n_fail++; $display("FAIL ct_read%0d: got %h expected %h", j, log_addr[f + 2 * j], 8'(8'h21 + j)); end
        end
        n_tests++; if (ep_cyc - log_cyc[f] !== 120) begin n_fail++; $display("FAIL ct_latency: got %0d expected 120", ep_cyc - log_cyc[f]); end
        n_tests++; if (ep_cnt - ep0 !== 1) begin n_fail++; $display("FAIL ct_epochs: got %0d expected 1", ep_cnt - ep0); end
        n_tests++; if (rsp_cnt - r0 !== acc_n) begin n_fail++; $display("FAIL ct_no_loss: got %0d expected %0d", rsp_cnt - r0, acc_n); end
        n_tests++; if (mem[8'h40] !== last_d) begin n_fail++; $display("FAIL ct_last_write: got %h expected %h", mem[8'h40], last_d); end
    endtask

    task automatic test_coherency;
        int base, ep0;
        bit found;
        logic [7:0] exp_a [10];
        exp_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        do_reset;
        base = log_n; ep0 = ep_cnt; found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            for (int j = base; j < log_n; j++) if (log_addr[j] == 8'h23 && !log_wr[j]) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL co_sweep_start: got none expected read 23"); end
        run_txn(1'b1, 8'h24, 8'hAA);
        for (int i = 0; i < 600 && ep_cnt == ep0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_tests++; if (ep_cnt - ep0 !== 1) begin n_fail++; $display("FAIL co_epochs: got %0d expected 1", ep_cnt - ep0); end
        n_tests++; if (log_n - base !== 10) begin n_fail++; $display("FAIL co_txns: got %0d expected 10", log_n - base); end
        for (int j = 0; j < 10; j++) begin
            n_tests++;
            if ({log_wr[base + j], log_addr[base + j]} !== {(j == 3), exp_a[j]}) begin
                n_fail++; $display("FAIL co_txn%0d: got %h expected %h", j, {log_wr[base + j], log_addr[base + j]}, {(j == 3), exp_a[j]});
            end
        end
        check_shadow("co", 8'h01, 8'h02, 8'h03, 8'hAA, 8'h05, 8'h06);
    endtask

    task automatic test_reset_dstb;
        int r0;
        bit acc;
        do_reset;
        acc = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_wdata = 8'h77;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin acc = 1'b1; break; end
        end
        n_tests++; if (!acc) begin n_fail++; $display("FAIL rd_accept: got ready=0 expected ready=1"); end
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if ({CS, AD, WR, bus_oe} !== 4'b0101) begin n_fail++; $display("FAIL rs_in_dstb: got %b expected 0101", {CS, AD, WR, bus_oe}); end
        r0 = rsp_cnt;
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if ({CS, AD, RD, WR, bus_oe} !== 5'b11110) begin n_fail++; $display("FAIL rs_strobes: got %b expected 11110", {CS, AD, RD, WR, bus_oe}); end
        n_tests++; if (bus_dout !== 8'h00) begin n_fail++; $display("FAIL rs_dout: got %h expected 00", bus_dout); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (15) @(negedge clk);
        n_tests++; if (rsp_cnt !== r0) begin n_fail++; $display("FAIL rs_no_rsp: got %0d expected %0d", rsp_cnt, r0); end
        shadow_sel = 3'd3; #1;
        n_tests++; if (shadow_data !== 8'h00) begin n_fail++; $display("FAIL rs_shadow: got %h expected 00", shadow_data); end
        run_txn(1'b1, 8'h51, 8'h12);
        n_tests++; if (tr_rv !== 13'b0100000000000) begin n_fail++; $display("FAIL rs_after_rsp: got %b expected 0100000000000", tr_rv); end
        n_tests++; if (mem[8'h51] !== 8'h12) begin n_fail++; $display("FAIL rs_after_mem: got %h expected 12", mem[8'h51]); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_sweep;
        test_contention;
        test_coherency;
        test_reset_dstb;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
